// File: rtl/axil_master_if.sv
// axil_master_if
//
// AXI4-Lite bus bundle between axil_master and an AXI4-Lite slave.
// Channels: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
// B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
// R (rdata/rresp/rvalid/rready).
// Modports: master (drives requests, consumes responses) and slave (mirror).
interface axil_master_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_master.sv
// axil_master
//
// Single-outstanding AXI4-Lite master. A simple application-side request
// (app_wen / app_ren strobes) is turned into one AXI4-Lite write or read;
// completion is reported with a one-cycle done pulse plus an error flag.
//
// Ports:
//   aclk, aresetn           clock (rising edge), asynchronous active-low reset
//   app_waddr/app_wdata     write request payload, sampled with app_wen
//   app_wen, app_wdone      write request strobe / one-cycle completion pulse
//   app_raddr               read address, sampled with app_ren
//   app_ren, app_rdone      read request strobe / one-cycle completion pulse
//   app_rdata               registered read result, held until next read done
//   app_err                 error flag, meaningful only with a done pulse
//   axi                     AXI4-Lite master bus (axil_master_if.master)
//
// Parameter TIMEOUT_CYCLES: cycles a transaction may spend outside IDLE.
// Optional feature macro AXIL_MASTER_TIMEOUT_EN: when defined, a watchdog
// aborts a transaction after TIMEOUT_CYCLES cycles (done pulse with error).
// When undefined, no counter exists and transactions wait indefinitely.
module axil_master #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [31:0]  app_waddr,
    input  logic [31:0]  app_wdata,
    input  logic         app_wen,
    output logic         app_wdone,
    input  logic [31:0]  app_raddr,
    input  logic         app_ren,
    output logic [31:0]  app_rdata,
    output logic         app_rdone,
    output logic         app_err,
    axil_master_if.master axi
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    state_t      state;
    state_t      state_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        aw_done;
    logic        w_done;

    logic        aw_pend;
    logic        w_pend;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;
    logic        ar_hs;
    logic        r_hs;

    logic        wr_fin;
    logic        rd_fin;
    logic        err_d;
    logic        timeout;

    // Only the SLVERR/DECERR bit of each response is of interest.
    logic        unused_resp_lsb;
    assign unused_resp_lsb = ^{axi.bresp[0], axi.rresp[0]};

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Counts cycles spent outside IDLE; value k-1 in the k-th such cycle,
    // so the abort fires at the end of the TIMEOUT_CYCLES-th cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign timeout = (state != IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    // Watchdog compiled out: the parameter is deliberately ignored.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Handshakes; each channel's valid is generated from state below.
    assign aw_hs = aw_pend && axi.awready;
    assign w_hs  = w_pend && axi.wready;
    assign b_hs  = axi.bready && axi.bvalid;
    assign ar_hs = axi.arvalid && axi.arready;
    assign r_hs  = axi.rready && axi.rvalid;

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic. Write wins over a simultaneous read request; the
    // watchdog overrides every non-IDLE state.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (app_wen) begin
                    state_d = WR_REQ;
                end else if (app_ren) begin
                    state_d = RD_REQ;
                end
            end
            WR_REQ: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                if (ar_hs) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d = IDLE;
        end
    end

    // AXI outputs. AW and W drop independently once their own handshake
    // has been recorded in aw_done / w_done.
    always_comb begin
        aw_pend     = (state == WR_REQ) && !aw_done;
        w_pend      = (state == WR_REQ) && !w_done;
        axi.awaddr  = addr_q;
        axi.awprot  = 3'b000;
        axi.awvalid = aw_pend;
        axi.wdata   = wdata_q;
        axi.wstrb   = 4'hF;
        axi.wvalid  = w_pend;
        axi.bready  = (state == WR_RESP);
        axi.araddr  = addr_q;
        axi.arprot  = 3'b000;
        axi.arvalid = (state == RD_REQ);
        axi.rready  = (state == RD_DATA);
    end

    // Completion decode. A real response in the abort cycle takes priority
    // so the slave's answer is reported rather than a forced error.
    always_comb begin
        wr_fin = 1'b0;
        rd_fin = 1'b0;
        err_d  = 1'b0;
        if (state == WR_RESP && b_hs) begin
            wr_fin = 1'b1;
            err_d  = axi.bresp[1];
        end else if (state == RD_DATA && r_hs) begin
            rd_fin = 1'b1;
            err_d  = axi.rresp[1];
        end else if (timeout) begin
            if (state == WR_REQ || state == WR_RESP) begin
                wr_fin = 1'b1;
                err_d  = 1'b1;
            end else if (state == RD_REQ || state == RD_DATA) begin
                rd_fin = 1'b1;
                err_d  = 1'b1;
            end
        end
    end

    // Request latching, per-channel handshake tracking and registered
    // application-side results.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            app_rdata <= '0;
            app_wdone <= 1'b0;
            app_rdone <= 1'b0;
            app_err   <= 1'b0;
        end else begin
            app_wdone <= wr_fin;
            app_rdone <= rd_fin;
            app_err   <= err_d;
            if (state == IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (app_wen) begin
                    addr_q  <= app_waddr;
                    wdata_q <= app_wdata;
                end else if (app_ren) begin
                    addr_q <= app_raddr;
                end
            end
            if (aw_hs) begin
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                w_done <= 1'b1;
            end
            if (state == RD_DATA && r_hs) begin
                app_rdata <= axi.rdata;
            end
        end
    end

endmodule

// File: tb/tb_axil_master.sv
// tb_axil_master
//
// Directed bench for axil_master. The stimulus process drives the app side
// and plays the AXI slave cycle by cycle; expected completions are queued
// and a separate monitor checks every app_wdone/app_rdone pulse against them.
// Build with AXIL_MASTER_TIMEOUT_EN defined to also exercise the watchdog.
module tb_axil_master;

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 256;
`endif

    typedef struct {
        logic        is_wr;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] app_waddr;
    logic [31:0] app_wdata;
    logic        app_wen;
    logic        app_wdone;
    logic [31:0] app_raddr;
    logic        app_ren;
    logic [31:0] app_rdata;
    logic        app_rdone;
    logic        app_err;

    int tests_run    = 0;
    int tests_failed = 0;

    exp_t sb[$];

    axil_master_if axi();

    axil_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .app_waddr (app_waddr),
        .app_wdata (app_wdata),
        .app_wen   (app_wen),
        .app_wdone (app_wdone),
        .app_raddr (app_raddr),
        .app_ren   (app_ren),
        .app_rdata (app_rdata),
        .app_rdone (app_rdone),
        .app_err   (app_err),
        .axi       (axi)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic wen, input logic ren,
                                 input logic [31:0] waddr, input logic [31:0] wdata,
                                 input logic [31:0] raddr);
        app_wen   = wen;
        app_ren   = ren;
        app_waddr = waddr;
        app_wdata = wdata;
        app_raddr = raddr;
    endtask

    task automatic pushExpect(input logic is_wr, input logic err, input logic [31:0] rdata);
        exp_t e;
        e.is_wr = is_wr;
        e.err   = err;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Advance one clock and land just after the edge.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge aclk);
            #2;
            if (app_wdone || app_rdone) begin
                if (sb.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_done: got wdone=%0b rdone=%0b, expected none",
                             app_wdone, app_rdone);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sb_wdone", {31'b0, app_wdone}, {31'b0, e.is_wr});
                    checkOutput("sb_rdone", {31'b0, app_rdone}, {31'b0, !e.is_wr});
                    checkOutput("sb_err", {31'b0, app_err}, {31'b0, e.err});
                    if (!e.is_wr) begin
                        checkOutput("sb_rdata", app_rdata, e.rdata);
                    end
                end
            end
        end
    end

    initial begin
        aresetn = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bresp   = 2'b00;
        axi.bvalid  = 1'b0;
        axi.arready = 1'b0;
        axi.rdata   = 32'h0;
        axi.rresp   = 2'b00;
        axi.rvalid  = 1'b0;
        #1;
        checkOutput("rst_valids", {27'b0, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 32'h0);
        checkOutput("rst_done_err", {29'b0, app_wdone, app_rdone, app_err}, 32'h0);
        checkOutput("rst_rdata", app_rdata, 32'h0);
        step();
        step();
        aresetn = 1'b1;
        step();

        // Write with all readys high: AW/W at 1, B at 2, done at 3.
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        axi.arready = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h10, 32'hCAFE0001, 32'h0);
        pushExpect(1'b1, 1'b0, 32'h0);
        step();
        checkOutput("t1_aw_w_valid_c1", {30'b0, axi.awvalid, axi.wvalid}, 32'h3);
        checkOutput("t1_awaddr", axi.awaddr, 32'h10);
        checkOutput("t1_wdata", axi.wdata, 32'hCAFE0001);
        checkOutput("t1_wstrb_prot", {22'b0, axi.wstrb, axi.awprot, axi.arprot}, 32'h3C0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        checkOutput("t1_aw_w_valid_c2", {30'b0, axi.awvalid, axi.wvalid}, 32'h0);
        checkOutput("t1_bready_c2", {31'b0, axi.bready}, 32'h1);
        axi.bvalid = 1'b1;
        axi.bresp  = 2'b00;
        step();
        checkOutput("t1_wdone_c3", {31'b0, app_wdone}, 32'h1);
        checkOutput("t1_bready_c3", {31'b0, axi.bready}, 32'h0);
        axi.bvalid = 1'b0;
        step();
        checkOutput("t1_wdone_c4", {31'b0, app_wdone}, 32'h0);

        // awready held low 3 cycles, wready immediate; stray ren while busy.
        axi.awready = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h14, 32'hA5A5A5A5, 32'h0);
        pushExpect(1'b1, 1'b0, 32'h0);
        step();
        checkOutput("t2_aw_w_c1", {30'b0, axi.awvalid, axi.wvalid}, 32'h3);
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 32'h99);
        step();
        checkOutput("t2_aw_w_c2", {30'b0, axi.awvalid, axi.wvalid}, 32'h2);
        checkOutput("t2_bready_c2", {31'b0, axi.bready}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        checkOutput("t2_aw_w_c3", {30'b0, axi.awvalid, axi.wvalid}, 32'h2);
        axi.awready = 1'b1;
        step();
        checkOutput("t2_aw_w_c4", {30'b0, axi.awvalid, axi.wvalid}, 32'h0);
        checkOutput("t2_bready_c4", {31'b0, axi.bready}, 32'h1);
        axi.bvalid = 1'b1;
        step();
        checkOutput("t2_wdone_c5", {31'b0, app_wdone}, 32'h1);
        axi.bvalid = 1'b0;
        step();
        checkOutput("t2_wdone_c6", {31'b0, app_wdone}, 32'h0);
        checkOutput("t2_no_arvalid", {31'b0, axi.arvalid}, 32'h0);

        // Read of 0x20 answered with SLVERR.
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 32'h20);
        pushExpect(1'b0, 1'b1, 32'h12345678);
        step();
        checkOutput("t3_arvalid_c1", {31'b0, axi.arvalid}, 32'h1);
        checkOutput("t3_araddr", axi.araddr, 32'h20);
        checkOutput("t3_rready_c1", {31'b0, axi.rready}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        checkOutput("t3_ar_r_c2", {30'b0, axi.arvalid, axi.rready}, 32'h1);
        axi.rvalid = 1'b1;
        axi.rdata  = 32'h12345678;
        axi.rresp  = 2'b10;
        step();
        checkOutput("t3_rdone_c3", {31'b0, app_rdone}, 32'h1);
        axi.rvalid = 1'b0;
        axi.rdata  = 32'h0;
        axi.rresp  = 2'b00;
        step();
        checkOutput("t3_rdone_c4", {31'b0, app_rdone}, 32'h0);
        checkOutput("t3_rdata_held", app_rdata, 32'h12345678);

        // wen and ren together: write only; then a read issued in the done cycle.
        applyStimulus(1'b1, 1'b1, 32'h40, 32'h55AA55AA, 32'h80);
        pushExpect(1'b1, 1'b1, 32'h0);
        step();
        checkOutput("t4_aw_c1", {31'b0, axi.awvalid}, 32'h1);
        checkOutput("t4_no_ar_c1", {31'b0, axi.arvalid}, 32'h0);
        checkOutput("t4_awaddr", axi.awaddr, 32'h40);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        checkOutput("t4_no_ar_c2", {31'b0, axi.arvalid}, 32'h0);
        axi.bvalid = 1'b1;
        axi.bresp  = 2'b10;
        step();
        checkOutput("t4_wdone_c3", {31'b0, app_wdone}, 32'h1);
        checkOutput("t4_no_ar_c3", {31'b0, axi.arvalid}, 32'h0);
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 32'h84);
        pushExpect(1'b0, 1'b0, 32'hDEADBEEF);
        step();
        checkOutput("t4_b2b_arvalid", {31'b0, axi.arvalid}, 32'h1);
        checkOutput("t4_b2b_araddr", axi.araddr, 32'h84);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        axi.rvalid = 1'b1;
        axi.rdata  = 32'hDEADBEEF;
        step();
        checkOutput("t4_rdone", {31'b0, app_rdone}, 32'h1);
        axi.rvalid = 1'b0;
        axi.rdata  = 32'h0;
        step();

        // Asynchronous reset while waiting in WR_RESP: no done for the write.
        applyStimulus(1'b1, 1'b0, 32'h60, 32'h0BADF00D, 32'h0);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        checkOutput("t5_bready_before", {31'b0, axi.bready}, 32'h1);
        aresetn = 1'b0;
        #1;
        checkOutput("t5_valids_async", {27'b0, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 32'h0);
        checkOutput("t5_rdata_cleared", app_rdata, 32'h0);
        checkOutput("t5_addr_cleared", axi.awaddr, 32'h0);
        axi.bvalid = 1'b1;
        step();
        step();
        checkOutput("t5_no_wdone", {31'b0, app_wdone}, 32'h0);
        axi.bvalid = 1'b0;
        aresetn = 1'b1;
        step();
        step();
        checkOutput("t5_idle_after", {27'b0, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 32'h0);

`ifdef AXIL_MASTER_TIMEOUT_EN
        // bvalid never arrives: abort after 8 non-IDLE cycles, done at cycle 9.
        applyStimulus(1'b1, 1'b0, 32'h70, 32'h00000001, 32'h0);
        pushExpect(1'b1, 1'b1, 32'h0);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (7) step();
        checkOutput("t6_bready_c8", {31'b0, axi.bready}, 32'h1);
        checkOutput("t6_wdone_c8", {31'b0, app_wdone}, 32'h0);
        step();
        checkOutput("t6_wdone_c9", {31'b0, app_wdone}, 32'h1);
        checkOutput("t6_err_c9", {31'b0, app_err}, 32'h1);
        checkOutput("t6_bready_c9", {31'b0, axi.bready}, 32'h0);
        step();
`endif

        step();
        checkOutput("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
